// File: rtl/inst_mem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Request/response layouts here use the default 8-bit opaque tag.
package InstMemPkg;

    localparam int MEM_WORD_BYTES  = 4;
    localparam int MEM_ADDR_BITS   = 32;
    localparam int MEM_DATA_BITS   = 32;
    localparam int MEM_OPAQUE_BITS = 8;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t                      op;
        logic [MEM_ADDR_BITS-1:0]     addr;
        logic [MEM_DATA_BITS-1:0]     data;
        logic [MEM_WORD_BYTES-1:0]    strb;
        logic [MEM_OPAQUE_BITS-1:0]   opaque;
    } mem_req_t;

    typedef struct packed {
        mem_op_t                      op;
        logic [MEM_DATA_BITS-1:0]     data;
        logic [MEM_OPAQUE_BITS-1:0]   opaque;
    } mem_resp_t;

endpackage

// File: rtl/inst_mem_responder_fifo.sv
// First-word-fallthrough response FIFO with same-cycle bypass: when empty,
// an incoming push is presented on the output immediately, and if it is
// popped in that same cycle it is never stored. Depth need not be a power
// of two; pointers wrap modulo p_depth.
module inst_mem_resp_fifo #(
    parameter int p_depth = 3,
    parameter int p_width = 41
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [p_width-1:0] i_push_data,
    input  logic               i_pop,
    output logic [p_width-1:0] o_data,
    output logic               o_valid,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CW = $clog2(p_depth + 1);

    logic [p_width-1:0] r_mem [p_depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_bypass;
    logic               w_wr_en;
    logic               w_rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(p_depth));
    assign o_valid  = !o_empty || i_push;
    assign o_data   = o_empty ? i_push_data : r_mem[r_rd_ptr];
    assign w_bypass = o_empty && i_push && i_pop;
    assign w_wr_en  = i_push && !w_bypass;
    assign w_rd_en  = i_pop && !o_empty;

    // Storage array: written only when the push is not consumed by bypass
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr_en && w_rd_en) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Overflow and underflow can never happen when the producer honours credits
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_wr_en && o_full && !w_rd_en));
            assert (!(i_pop && !o_valid));
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: val/rdy requests access a word SRAM in the
// accept cycle, ride a p_latency-deep pipe, and leave through an FWFT
// response FIFO. A credit counter (p_latency+1 credits) bounds the number
// of requests in flight so a response always has a FIFO slot.
// Optional build macro INST_MEM_RESPONDER_RANDOM_DELAY_EN adds an LFSR that
// randomly stalls the response port to stretch latency.
import InstMemPkg::*;

module inst_mem_responder #(
    parameter int p_depth       = 256,
    parameter int p_latency     = 2,
    parameter int p_opaque_bits = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_op,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    input  logic [3:0]               req_strb,
    input  logic [p_opaque_bits-1:0] req_opaque,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_op,
    output logic [31:0]              resp_data,
    output logic [p_opaque_bits-1:0] resp_opaque
);

    localparam int C      = p_latency + 1;
    localparam int CRED_W = $clog2(C + 1);
    localparam int IDX_W  = $clog2(p_depth);
    localparam int RESP_W = 1 + 32 + p_opaque_bits;

    logic [31:0]              r_mem      [p_depth];
    logic [31:0]              r_pipe_data[p_latency];
    logic                     r_pipe_val [p_latency];
    mem_op_t                  r_pipe_op  [p_latency];
    logic [p_opaque_bits-1:0] r_pipe_opq [p_latency];
    logic [CRED_W-1:0]        r_credits;
    logic [CRED_W-1:0]        w_credits_next;
    logic [IDX_W-1:0]         w_word_idx;
    mem_op_t                  w_req_op;
    mem_op_t                  w_out_op;
    logic                     w_req_fire;
    logic                     w_resp_fire;
    logic                     w_stall;
    logic [RESP_W-1:0]        w_push_data;
    logic [RESP_W-1:0]        w_fifo_data;
    logic                     w_fifo_valid;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_unused;

    // Byte offset and address bits above the SRAM size are ignored (aliasing)
    assign w_word_idx = req_addr[2 +: IDX_W];
    assign w_unused   = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
    assign w_req_op   = mem_op_t'(req_op);

    assign req_rdy     = rst && (r_credits != '0);
    assign w_req_fire  = req_val && req_rdy;
    assign resp_val    = rst && w_fifo_valid && !w_stall;
    assign w_resp_fire = resp_val && resp_rdy;

    // SRAM byte-strobed write plus read-before-write capture, and data pipe shift
    always_ff @(posedge clk) begin
        if (w_req_fire && (w_req_op == MEM_WRITE)) begin
            for (int b = 0; b < MEM_WORD_BYTES; b++) begin
                if (req_strb[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
        r_pipe_data[0] <= r_mem[w_word_idx];
        for (int k = 1; k < p_latency; k++) begin
            r_pipe_data[k] <= r_pipe_data[k-1];
        end
    end

    // Control pipe: valid bits are cleared by reset, op/tag just follow along
    always_ff @(posedge clk) begin
        r_pipe_op[0]  <= w_req_op;
        r_pipe_opq[0] <= req_opaque;
        for (int k = 1; k < p_latency; k++) begin
            r_pipe_op[k]  <= r_pipe_op[k-1];
            r_pipe_opq[k] <= r_pipe_opq[k-1];
        end
        if (!rst) begin
            for (int k = 0; k < p_latency; k++) begin
                r_pipe_val[k] <= 1'b0;
            end
        end else begin
            r_pipe_val[0] <= w_req_fire;
            for (int k = 1; k < p_latency; k++) begin
                r_pipe_val[k] <= r_pipe_val[k-1];
            end
        end
    end

    // Write responses carry zero data
    assign w_out_op    = r_pipe_op[p_latency-1];
    assign w_push_data = {w_out_op,
                          (w_out_op == MEM_WRITE) ? 32'h0 : r_pipe_data[p_latency-1],
                          r_pipe_opq[p_latency-1]};

    inst_mem_resp_fifo #(
        .p_depth (C),
        .p_width (RESP_W)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_pipe_val[p_latency-1]),
        .i_push_data (w_push_data),
        .i_pop       (w_resp_fire),
        .o_data      (w_fifo_data),
        .o_valid     (w_fifo_valid),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign {resp_op, resp_data, resp_opaque} = w_fifo_data;

    // Credit next-state: accept consumes, response fire returns
    always_comb begin
        w_credits_next = r_credits;
        if (w_req_fire && !w_resp_fire) begin
            w_credits_next = r_credits - 1'b1;
        end else if (!w_req_fire && w_resp_fire) begin
            w_credits_next = r_credits + 1'b1;
        end
    end

    // Credit register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credits <= CRED_W'(C);
        end else begin
            r_credits <= w_credits_next;
        end
    end

    // A full FIFO implies no credits left; all credits back implies nothing buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!w_fifo_full || (r_credits == '0));
            assert ((r_credits != CRED_W'(C)) || w_fifo_empty);
        end
    end

`ifdef INST_MEM_RESPONDER_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, free-running
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed + randomized bench for inst_mem_responder (default parameters).
// Reference: word array + expected-response queue updated on each accept.
module tb_inst_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic [7:0]  req_opaque;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_op;
    logic [31:0] resp_data;
    logic [7:0]  resp_opaque;

    inst_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_strb    (req_strb),
        .req_opaque  (req_opaque),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_data   (resp_data),
        .resp_opaque (resp_opaque)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        op;
        logic [31:0] data;
        logic [7:0]  opq;
        int          cyc;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] model_mem [256];
    exp_t        expq [$];
    bit          chk_lat;
    bit          last_acc;
    bit          last_pop;
    bit          last_req_rdy;
    bit          last_resp_val;
    logic [31:0] last_pop_data;
    bit          hold_valid;
    logic [40:0] hold_payload;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample at negedge, score, update model, advance past posedge
    task automatic step();
        exp_t       e;
        logic [7:0] w;
        @(negedge clk);
        last_req_rdy  = req_rdy;
        last_resp_val = resp_val;
        last_acc      = req_val && req_rdy;
        last_pop      = resp_val && resp_rdy;
        if (hold_valid && resp_val)
            chk("hold_stable", 64'({resp_op, resp_data, resp_opaque}), 64'(hold_payload));
        hold_valid   = resp_val && !resp_rdy;
        hold_payload = {resp_op, resp_data, resp_opaque};
        if (last_pop) begin
            if (expq.size() == 0) begin
                chk("spurious_resp", 64'(resp_val), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("resp_payload", 64'({resp_op, resp_data, resp_opaque}), 64'({e.op, e.data, e.opq}));
                if (chk_lat) chk("resp_latency", 64'(cyc - e.cyc), 64'(LAT));
                last_pop_data = resp_data;
            end
        end
        if (last_acc) begin
            w     = req_addr[9:2];
            e.op  = req_op;
            e.opq = req_opaque;
            e.cyc = cyc;
            if (req_op) begin
                for (int b = 0; b < 4; b++)
                    if (req_strb[b]) model_mem[w][8*b +: 8] = req_data[8*b +: 8];
                e.data = 32'h0;
            end else begin
                e.data = model_mem[w];
            end
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [7:0] opq);
        req_val    = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_data   = data;
        req_strb   = strb;
        req_opaque = opq;
    endtask

    task automatic send(input logic op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [7:0] opq);
        bit done = 1'b0;
        set_req(op, addr, data, strb, opq);
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = last_acc;
        end
        req_val = 1'b0;
        chk("send_accept", 64'(done), 64'(1));
    endtask

    task automatic drain();
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 60 && expq.size() != 0; i++) step();
        chk("drain_empty", 64'(expq.size()), 64'(0));
    endtask

    initial begin
        int n;
        int pops;
        int first_pop;
        int rdy_cyc;

        rst = 1'b0; req_val = 1'b0; req_op = 1'b0; req_addr = '0;
        req_data = '0; req_strb = '0; req_opaque = '0; resp_rdy = 1'b1;
        chk_lat = 1'b0; hold_valid = 1'b0; last_pop_data = '0;

        // Reset state
        repeat (3) step();
        chk("rst_req_rdy", 64'(last_req_rdy), 64'(0));
        chk("rst_resp_val", 64'(last_resp_val), 64'(0));
        rst = 1'b1;
        step();
        chk("post_rst_req_rdy", 64'(last_req_rdy), 64'(1));
        chk("post_rst_resp_val", 64'(last_resp_val), 64'(0));

        // Fill every word so the model is fully known
        chk_lat = 1'b1;
        for (int i = 0; i < 256; i++) send(1'b1, 32'(i * 4), $urandom, 4'hF, 8'(i));
        drain();

        // Write then read on consecutive cycles
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 8'd3);
        send(1'b0, 32'h10, 32'h0, 4'h0, 8'd4);
        drain();
        chk("wr_rd_data", 64'(last_pop_data), 64'(32'hDEADBEEF));

        // Byte strobes
        send(1'b1, 32'h20, 32'h11223344, 4'hF, 8'd5);
        send(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 8'd6);
        send(1'b0, 32'h20, 32'h0, 4'h0, 8'd7);
        drain();
        chk("strb_data", 64'(last_pop_data), 64'(32'h11BB33DD));

        // Backpressure: exactly C=3 accepts, then ready returns one cycle after first pop
        chk_lat = 1'b0;
        resp_rdy = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            set_req(1'b0, $urandom, 32'h0, 4'h0, 8'(8'h80 + k));
            step();
            if (last_acc) n++;
        end
        req_val = 1'b0;
        chk("bp_accepts", 64'(n), 64'(3));
        chk("bp_req_rdy_low", 64'(last_req_rdy), 64'(0));
        chk("bp_resp_waiting", 64'(last_resp_val), 64'(1));
        resp_rdy = 1'b1;
        pops = 0; first_pop = -1; rdy_cyc = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_pop) begin
                pops++;
                if (first_pop < 0) first_pop = cyc - 1;
            end
            if (last_req_rdy && rdy_cyc < 0) rdy_cyc = cyc - 1;
        end
        chk("bp_pops", 64'(pops), 64'(3));
        chk("bp_rdy_return", 64'(rdy_cyc - first_pop), 64'(1));
        chk("bp_queue_empty", 64'(expq.size()), 64'(0));

        // Streaming: 64 back-to-back reads, every response exactly LAT later
        chk_lat = 1'b1;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            set_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 8'(i));
            step();
            if (last_acc) n++;
        end
        req_val = 1'b0;
        chk("stream_accepts", 64'(n), 64'(64));
        drain();

        // Reset with two reads in flight
        chk_lat = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0, 8'h40);
        send(1'b0, 32'h14, 32'h0, 4'h0, 8'h41);
        rst = 1'b0;
        step();
        chk("midrst_resp_val", 64'(last_resp_val), 64'(0));
        chk("midrst_req_rdy", 64'(last_req_rdy), 64'(0));
        expq.delete();
        rst = 1'b1;
        repeat (5) step();
        chk("after_rst_resp_val", 64'(last_resp_val), 64'(0));
        chk("after_rst_req_rdy", 64'(last_req_rdy), 64'(1));
        resp_rdy = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            set_req(1'b0, $urandom, 32'h0, 4'h0, 8'(8'h50 + k));
            step();
            if (last_acc) n++;
        end
        req_val = 1'b0;
        chk("after_rst_credits", 64'(n), 64'(3));
        drain();
        send(1'b0, 32'h10, 32'h0, 4'h0, 8'h60);
        drain();
        chk("after_rst_mem", 64'(last_pop_data), 64'(32'hDEADBEEF));

        // Aliasing beyond the SRAM size
        send(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 8'h61);
        send(1'b0, 32'h400, 32'h0, 4'h0, 8'h62);
        drain();
        chk("alias_data", 64'(last_pop_data), 64'(32'h5A5A5A5A));

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            set_req(1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            req_val  = ($urandom_range(0, 3) != 0);
            resp_rdy = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
